mac_seq_unit: RTL and testbench
===============================

// Module: mac_seq_unit
// PURPOSE
//  Sequential, parametrised multiply-accumulate: res = (a*b + addend) mod 2^W.
//  Radix-2 shift-add datapath, one multiplier bit per cycle, valid/ready on both sides.
//  Successor to the fixed 4-bit combinational multiply-add; adds width generality,
//  a handshake, back-pressure and a chained-accumulate mode.
// PARAMETERS
//  W        4   operand/result width in bits (>=2)
//  CNT_W    $clog2(W+1)   derived; bit-counter width (localparam, not overridable)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operand set valid
//  in_ready   out  1   block can accept operands
//  in_a       in   W   multiplicand
//  in_b       in   W   multiplier
//  in_c       in   W   addend (ignored when in_acc=1)
//  in_acc     in   1   1: addend = previous committed result
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  out_res    out  W   (a*b + addend) mod 2^W
//  out_ovf    out  1   only with MAC_OVF_EN: true sum >= 2^W
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_res=0, out_ovf=0, prev-result reg=0.
//  FSM: IDLE -> CALC on in_valid&in_ready; CALC -> DONE after exactly W CALC cycles;
//   DONE -> IDLE on out_ready; DONE -> CALC if out_ready & in_valid (back-to-back).
//  in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready low throughout CALC.
//  Accept cycle t: latch a, b; acc <= in_acc ? prev : in_c; bit counter <= 0.
//  CALC cycle k (k=0..W-1): if b[k], acc <= acc + (a << k) truncated to W bits.
//  out_valid rises at cycle t+W+1; latency W+1 regardless of operand values (b=0 too).
//  out_res/out_ovf stable while out_valid & !out_ready; not updated until handshake.
//  On out handshake, prev <= out_res; prev changes only on completed handshake.
//  in_acc=1 for first op after reset uses prev=0.
//  Inputs sampled only on accept; changes during CALC/DONE have no effect.
//  rst_n low mid-CALC or mid-DONE: in-flight op discarded, all regs to reset values,
//   no out_valid emitted for it.
// CONFIGURATION
//  MAC_OVF_EN defined: out_ovf port present; datapath keeps a 2W+1-bit shadow sum,
//   out_ovf=1 iff a*b + addend >= 2^W; cleared on accept of next op.
//  MAC_OVF_EN undefined: no out_ovf port, shadow logic absent, W-bit datapath only.
// STRUCTURE
//  Shared package mac_pkg: typedef enum {IDLE, CALC, DONE} mac_state_t; width helper fn.
//  One sub-module: mac_shift_add_dp (acc register, shifted-a adder, bit counter, ovf
//   shadow); FSM + handshake stay in mac_seq_unit.
// TESTING (W=4 unless noted)
//  a=3,b=5,c=2 -> out_res=1 at t+5; out_ovf=1 (17>=16) with MAC_OVF_EN.
//  a=F,b=F,c=F -> out_res=0 (240 mod 16), out_ovf=1; a=2,b=3,c=1 -> 7, ovf=0.
//  Chain: a=2,b=2,c=1 (->5), then in_acc=1,a=3,b=1 -> 8; then in_acc=1,a=3,b=3 -> 1.
//  Back-pressure: hold out_ready=0 10 cycles -> out_res stable, in_ready=0; then
//   out_ready=1 with in_valid=1 -> new op accepted same cycle, next result at +5.
//  b=0,c=9 -> out_res=9 after exactly 5 cycles; W=8: a=FF,b=FF,c=1 -> 02.
//  rst_n pulsed low mid-CALC -> out_valid=0, in_ready=1, next in_acc op uses prev=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the sequential multiply-accumulate unit.
//   mac_state_t : control FSM states (IDLE, CALC, DONE)
//   cnt_width() : width of a counter able to hold the values 0..w
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mac_shift_add_dp.sv
// Radix-2 shift-add datapath for mac_seq_unit: one multiplier bit per step.
// Optional feature macro: MAC_OVF_EN (adds a 2W+1-bit shadow sum and ovf_o).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture operands; acc <= addend_i, bit counter <= 0
//   step_i     : process one multiplier bit (LSB first)
//   a_i, b_i   : multiplicand, multiplier
//   addend_i   : initial accumulator value
//   last_o     : current step handles the final multiplier bit
//   acc_o      : W-bit accumulator (the result once all bits are processed)
//   ovf_o      : (MAC_OVF_EN) full-precision sum >= 2^W
module mac_shift_add_dp
  import mac_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] addend_i,
  output logic         last_o,
  output logic [W-1:0] acc_o
`ifdef MAC_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(W);

  // a shifts left and b shifts right each step, so the active multiplier bit
  // is always b_q[0] and the partial product is always a_q.
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = addend_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = step_i & (cnt_q == CNT_W'(W - 1));
  assign acc_o  = acc_q;

`ifdef MAC_OVF_EN
  // Shadow copy without truncation; a*b + addend < 2^(2W) + 2^W fits 2W+1 bits.
  logic [2*W-1:0] wa_q, wa_d;
  logic [2*W:0]   sum_q, sum_d;

  always_comb begin
    wa_d  = wa_q;
    sum_d = sum_q;
    if (load_i) begin
      wa_d  = {{W{1'b0}}, a_i};
      sum_d = {{(W + 1){1'b0}}, addend_i};
    end else if (step_i) begin
      if (b_q[0]) sum_d = sum_q + {1'b0, wa_q};
      wa_d = wa_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q  <= '0;
      sum_q <= '0;
    end else begin
      wa_q  <= wa_d;
      sum_q <= sum_d;
    end
  end

  assign ovf_o = |sum_q[2*W:W];
`endif

endmodule

// File: rtl/mac_seq_unit.sv
// Sequential multiply-accumulate: res = (a*b + addend) mod 2^W, W+1 cycle latency.
// Optional feature macro: MAC_OVF_EN (adds out_ovf_o).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : operand handshake
//   in_a_i, in_b_i, in_c_i   : multiplicand, multiplier, addend
//   in_acc_i                 : 1 = use previous committed result as addend
//   out_valid_o / out_ready_i: result handshake
//   out_res_o                : result, held until the consumer accepts it
//   out_ovf_o                : (MAC_OVF_EN) true sum >= 2^W
module mac_seq_unit
  import mac_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  input  logic [W-1:0] in_c_i,
  input  logic         in_acc_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_res_o
`ifdef MAC_OVF_EN
  ,
  output logic         out_ovf_o
`endif
);

  mac_state_t   state_q;
  logic         out_valid_q;
  logic [W-1:0] prev_q;
  logic         accept;
  logic         last;
  logic [W-1:0] addend;
  logic [W-1:0] res;

  assign in_ready_o = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  // A back-to-back accept from DONE commits the current result in the same
  // cycle, so a chained op forwards it instead of the stale prev_q.
  assign addend = in_acc_i ? ((state_q == DONE) ? res : prev_q) : in_c_i;

  mac_shift_add_dp #(
    .W(W)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .step_i  (state_q == CALC),
    .a_i     (in_a_i),
    .b_i     (in_b_i),
    .addend_i(addend),
    .last_o  (last),
    .acc_o   (res)
`ifdef MAC_OVF_EN
    ,
    .ovf_o   (out_ovf_o)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      prev_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_q <= CALC;
        end
        CALC: begin
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            prev_q      <= res;
            out_valid_q <= 1'b0;
            state_q     <= accept ? CALC : IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_res_o   = res;

endmodule

// File: tb/tb_mac_seq_unit.sv
module tb_mac_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // W=4 instance
  logic       in_valid = 1'b0, in_ready, in_acc = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, in_c = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [3:0] out_res;
`ifdef MAC_OVF_EN
  logic       out_ovf;
`endif

  // W=8 instance
  logic       in_valid8 = 1'b0, in_ready8, in_acc8 = 1'b0;
  logic [7:0] in_a8 = '0, in_b8 = '0, in_c8 = '0;
  logic       out_valid8, out_ready8 = 1'b0;
  logic [7:0] out_res8;
`ifdef MAC_OVF_EN
  logic       out_ovf8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_seq_unit #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .in_c_i     (in_c),
    .in_acc_i   (in_acc),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_res_o  (out_res)
`ifdef MAC_OVF_EN
    ,
    .out_ovf_o  (out_ovf)
`endif
  );

  mac_seq_unit #(.W(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid8),
    .in_ready_o (in_ready8),
    .in_a_i     (in_a8),
    .in_b_i     (in_b8),
    .in_c_i     (in_c8),
    .in_acc_i   (in_acc8),
    .out_valid_o(out_valid8),
    .out_ready_i(out_ready8),
    .out_res_o  (out_res8)
`ifdef MAC_OVF_EN
    ,
    .out_ovf_o  (out_ovf8)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       acc;
    logic [3:0] res;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  // Launch one op from IDLE, scramble inputs during CALC, wait, sample, handshake.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic acc, output logic [3:0] res, output logic ovf,
                       output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_acc = acc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 4'($urandom); in_b = 4'($urandom); in_c = 4'($urandom); in_acc = 1'($urandom);
    wait_valid(lat);
    @(negedge clk);
    res = out_res;
`ifdef MAC_OVF_EN
    ovf = out_ovf;
`else
    ovf = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic       o;
    int         lat;

    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r;
    logic       o;
    int         lat;

    vecs[0] = '{4'h3, 4'h5, 4'h2, 1'b0, 4'h1, 1'b1};  // 17
    vecs[1] = '{4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1};  // 240
    vecs[2] = '{4'h2, 4'h3, 4'h1, 1'b0, 4'h7, 1'b0};  // 7
    vecs[3] = '{4'h2, 4'h2, 4'h1, 1'b0, 4'h5, 1'b0};  // 5
    vecs[4] = '{4'h3, 4'h1, 4'h0, 1'b1, 4'h8, 1'b0};  // 3 + 5
    vecs[5] = '{4'h3, 4'h3, 4'h0, 1'b1, 4'h1, 1'b1};  // 9 + 8 = 17
    vecs[6] = '{4'h7, 4'h0, 4'h9, 1'b0, 4'h9, 1'b0};  // b=0 still W+1 latency
    vecs[7] = '{4'h5, 4'h1, 4'h0, 1'b1, 4'hE, 1'b0};  // 5 + 9
    vecs[8] = '{4'h8, 4'h2, 4'h0, 1'b0, 4'h0, 1'b1};  // 16

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", 32'(out_res), 32'd0);
`ifdef MAC_OVF_EN
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].acc, r, o, lat);
      check($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
`ifdef MAC_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
`endif
    end

    // Back-pressure: 6*7 = 42 -> 0xA held while the consumer stalls, and a
    // pending operand set must not be accepted until the result is taken.
    @(negedge clk);
    in_a = 4'h6; in_b = 4'h7; in_c = 4'h0; in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd5);
    @(negedge clk);
    in_a = 4'h1; in_b = 4'h1; in_c = 4'h1; in_acc = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_res_%0d", k), 32'(out_res), 32'hA);
      check($sformatf("bp_hold_ready_%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
    end
`ifdef MAC_OVF_EN
    check("bp_ovf", 32'(out_ovf), 32'd1);
`endif
    out_ready = 1'b1;
    #1;
    check("bp_b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    wait_valid(lat);
    check("bp_b2b_latency", 32'(lat), 32'd5);
    @(negedge clk);
    check("bp_b2b_res", 32'(out_res), 32'h2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Chain after the stalled sequence: prev must be the last committed 2.
    do_op(4'h1, 4'h1, 4'hF, 1'b1, r, o, lat);
    check("chain_after_bp", 32'(r), 32'h3);

    // Reset in the middle of CALC: op discarded, prev cleared.
    @(negedge clk);
    in_a = 4'h3; in_b = 4'h3; in_c = 4'h4; in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_res", 32'(out_res), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_result", 32'(seen), 32'd0);
    end
    do_op(4'h1, 4'h1, 4'h7, 1'b1, r, o, lat);
    check("midrst_prev_zero", 32'(r), 32'h1);

    // W=8: 0xFF*0xFF + 1 = 0xFE02
    @(negedge clk);
    in_a8 = 8'hFF; in_b8 = 8'hFF; in_c8 = 8'h01; in_acc8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("w8_latency", 32'(lat), 32'd9);
    check("w8_res", 32'(out_res8), 32'h02);
`ifdef MAC_OVF_EN
    check("w8_ovf", 32'(out_ovf8), 32'd1);
`endif
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    check("w8_idle_after", 32'(out_valid8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
